// File: rtl/uart_stream_router.sv
// uart_stream_router
//    Buffering and routing stage between a UART RX core, a byte processor
//    and a UART TX core. Received bytes queue in an RX FIFO and are routed
//    according to a registered route mode: to the processor (paced by a gap
//    counter), looped straight into the TX FIFO, or discarded. A handshake
//    FSM drains the TX FIFO into the TX core. Overflow drops on either FIFO
//    are counted in saturating statistics counters.
//
// Ports
//    i_Clk, rst          clock (rising edge), asynchronous active-high reset
//    i_Mode              route mode: 0 processed, 1 loopback, 2/3 discard
//    i_Clr_Stats         synchronous clear of both overflow counters
//    i_Rx_DV/i_Rx_Byte   byte strobe from the RX core
//    o_Proc_DV/_Byte     paced byte strobe to the processor
//    i_Proc_DV/_Byte     processed byte strobe from the processor
//    i_Tx_Active         TX core busy (holds the FSM in IDLE)
//    i_Tx_Done           TX core completion strobe
//    o_Tx_DV/o_Tx_Byte   start strobe and held byte for the TX core
//    o_Rx/Tx_Level       FIFO occupancies
//    o_Rx/Tx_Ovf_Cnt     saturating counts of pushes dropped on a full FIFO
module uart_stream_router #(
   parameter int DATA_W   = 8,
   parameter int RX_DEPTH = 16,
   parameter int TX_DEPTH = 16,
   parameter int PROC_GAP = 0,
   parameter int CNT_W    = 16
) (
   input  logic                      i_Clk,
   input  logic                      rst,
   input  logic [1:0]                i_Mode,
   input  logic                      i_Clr_Stats,
   input  logic                      i_Rx_DV,
   input  logic [DATA_W-1:0]         i_Rx_Byte,
   output logic                      o_Proc_DV,
   output logic [DATA_W-1:0]         o_Proc_Byte,
   input  logic                      i_Proc_DV,
   input  logic [DATA_W-1:0]         i_Proc_Byte,
   input  logic                      i_Tx_Active,
   input  logic                      i_Tx_Done,
   output logic                      o_Tx_DV,
   output logic [DATA_W-1:0]         o_Tx_Byte,
   output logic [$clog2(RX_DEPTH):0] o_Rx_Level,
   output logic [$clog2(TX_DEPTH):0] o_Tx_Level,
   output logic [CNT_W-1:0]          o_Rx_Ovf_Cnt,
   output logic [CNT_W-1:0]          o_Tx_Ovf_Cnt
);

   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int GAP_W = (PROC_GAP > 0) ? $clog2(PROC_GAP + 1) : 1;

   localparam logic [RX_AW:0]     RX_FULL  = RX_DEPTH[RX_AW:0];
   localparam logic [TX_AW:0]     TX_FULL  = TX_DEPTH[TX_AW:0];
   localparam logic [GAP_W-1:0]   GAP_LOAD = PROC_GAP[GAP_W-1:0];

   typedef enum logic [1:0] {
      ROUTE_PROC     = 2'd0,
      ROUTE_LOOP     = 2'd1,
      ROUTE_DROP     = 2'd2,
      ROUTE_DROP_ALT = 2'd3
   } route_e;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_WAIT
   } tx_state_e;

   route_e            mode_q;
   tx_state_e         tx_state, tx_next;

   logic [DATA_W-1:0] rx_mem [RX_DEPTH];
   logic [RX_AW-1:0]  rx_wr_ptr, rx_rd_ptr;
   logic              rx_empty, rx_full, rx_push_ok, rx_pop;
   logic [DATA_W-1:0] rx_head;

   logic [DATA_W-1:0] tx_mem [TX_DEPTH];
   logic [TX_AW-1:0]  tx_wr_ptr, tx_rd_ptr;
   logic              tx_empty, tx_full, tx_push, tx_push_ok, tx_pop;
   logic [DATA_W-1:0] tx_head, tx_push_data;

   logic [GAP_W-1:0]  gap_cnt;
   logic              proc_fire;

   // ------------------------------------------------------------------
   // Route mode register: a mode change applies from the following cycle
   // ------------------------------------------------------------------
   always_ff @(posedge i_Clk or posedge rst) begin
      if (rst) mode_q <= ROUTE_PROC;
      else     mode_q <= route_e'(i_Mode);
   end

   // ------------------------------------------------------------------
   // RX FIFO
   // ------------------------------------------------------------------
   assign rx_empty   = (o_Rx_Level == '0);
   assign rx_full    = (o_Rx_Level == RX_FULL);
   assign rx_push_ok = i_Rx_DV && !rx_full;
   assign rx_head    = rx_mem[rx_rd_ptr];

   always_ff @(posedge i_Clk) begin
      if (rx_push_ok) rx_mem[rx_wr_ptr] <= i_Rx_Byte;
   end

   always_ff @(posedge i_Clk or posedge rst) begin
      if (rst) begin
         rx_wr_ptr  <= '0;
         rx_rd_ptr  <= '0;
         o_Rx_Level <= '0;
      end else begin
         if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_pop)     rx_rd_ptr <= rx_rd_ptr + 1'b1;
         case ({rx_push_ok, rx_pop})
            2'b10:   o_Rx_Level <= o_Rx_Level + 1'b1;
            2'b01:   o_Rx_Level <= o_Rx_Level - 1'b1;
            default: o_Rx_Level <= o_Rx_Level;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Routing: RX drain and TX push source selected by the route mode
   // ------------------------------------------------------------------
   always_comb begin
      rx_pop       = 1'b0;
      proc_fire    = 1'b0;
      tx_push      = 1'b0;
      tx_push_data = i_Proc_Byte;
      case (mode_q)
         ROUTE_PROC: begin
            proc_fire    = !rx_empty && (gap_cnt == '0);
            rx_pop       = proc_fire;
            tx_push      = i_Proc_DV;
            tx_push_data = i_Proc_Byte;
         end
         ROUTE_LOOP: begin
            // Only move a byte when TX can take it, so loopback never overflows
            rx_pop       = !rx_empty && !tx_full;
            tx_push      = rx_pop;
            tx_push_data = rx_head;
         end
         default: begin
            rx_pop = !rx_empty;
         end
      endcase
   end

   // Processor strobe and pacing gap counter
   always_ff @(posedge i_Clk or posedge rst) begin
      if (rst) begin
         o_Proc_DV   <= 1'b0;
         o_Proc_Byte <= '0;
         gap_cnt     <= '0;
      end else begin
         o_Proc_DV <= proc_fire;
         if (proc_fire) begin
            o_Proc_Byte <= rx_head;
            gap_cnt     <= GAP_LOAD;
         end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // TX FIFO
   // ------------------------------------------------------------------
   assign tx_empty   = (o_Tx_Level == '0);
   assign tx_full    = (o_Tx_Level == TX_FULL);
   assign tx_push_ok = tx_push && !tx_full;
   assign tx_head    = tx_mem[tx_rd_ptr];

   always_ff @(posedge i_Clk) begin
      if (tx_push_ok) tx_mem[tx_wr_ptr] <= tx_push_data;
   end

   always_ff @(posedge i_Clk or posedge rst) begin
      if (rst) begin
         tx_wr_ptr  <= '0;
         tx_rd_ptr  <= '0;
         o_Tx_Level <= '0;
      end else begin
         if (tx_push_ok) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop)     tx_rd_ptr <= tx_rd_ptr + 1'b1;
         case ({tx_push_ok, tx_pop})
            2'b10:   o_Tx_Level <= o_Tx_Level + 1'b1;
            2'b01:   o_Tx_Level <= o_Tx_Level - 1'b1;
            default: o_Tx_Level <= o_Tx_Level;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // TX handshake FSM
   // ------------------------------------------------------------------
   always_ff @(posedge i_Clk or posedge rst) begin
      if (rst) tx_state <= TX_IDLE;
      else     tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      o_Tx_DV = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (!tx_empty && !i_Tx_Active) begin
               tx_pop  = 1'b1;
               tx_next = TX_START;
            end
         end
         TX_START: begin
            o_Tx_DV = 1'b1;
            tx_next = TX_WAIT;
         end
         TX_WAIT: begin
            if (i_Tx_Done) tx_next = TX_IDLE;
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   // Byte is captured on the pop and held until the next pop
   always_ff @(posedge i_Clk or posedge rst) begin
      if (rst)         o_Tx_Byte <= '0;
      else if (tx_pop) o_Tx_Byte <= tx_head;
   end

   // ------------------------------------------------------------------
   // Saturating overflow statistics; clear wins over a same-cycle drop
   // ------------------------------------------------------------------
   always_ff @(posedge i_Clk or posedge rst) begin
      if (rst) begin
         o_Rx_Ovf_Cnt <= '0;
         o_Tx_Ovf_Cnt <= '0;
      end else if (i_Clr_Stats) begin
         o_Rx_Ovf_Cnt <= '0;
         o_Tx_Ovf_Cnt <= '0;
      end else begin
         if (i_Rx_DV && rx_full && (o_Rx_Ovf_Cnt != '1))
            o_Rx_Ovf_Cnt <= o_Rx_Ovf_Cnt + 1'b1;
         if (tx_push && tx_full && (o_Tx_Ovf_Cnt != '1))
            o_Tx_Ovf_Cnt <= o_Tx_Ovf_Cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_stream_router.sv
// tb_uart_stream_router
//    Directed bench for uart_stream_router. Two instances share one set of
//    stimulus inputs; every test starts from a reset pulse.
//      dut_a: RX_DEPTH 16, TX_DEPTH 4, PROC_GAP 3, CNT_W 2
//      dut_b: RX_DEPTH 4, PROC_GAP 100 (stalled processor for RX overflow)
//    A TX core model answers dut_a's o_Tx_DV with i_Tx_Done 20 cycles later,
//    and an optional processor echo returns the inverse of each dut_a byte.
module tb_uart_stream_router;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] mode = 2'd0;
   logic       clr = 1'b0;
   logic       rx_dv = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       tb_proc_dv = 1'b0;
   logic [7:0] tb_proc_byte = 8'h00;
   logic       hold_active = 1'b0;
   logic       echo_en = 1'b0;

   logic       echo_dv = 1'b0;
   logic [7:0] echo_byte = 8'h00;
   logic       tx_busy = 1'b0;
   logic       tx_done = 1'b0;
   int         tx_cnt = 0;

   logic       proc_dv_in;
   logic [7:0] proc_byte_in;
   logic       tx_active_in;

   assign proc_dv_in   = echo_dv | tb_proc_dv;
   assign proc_byte_in = echo_en ? echo_byte : tb_proc_byte;
   assign tx_active_in = tx_busy | hold_active;

   logic       a_proc_dv, a_tx_dv;
   logic [7:0] a_proc_byte, a_tx_byte;
   logic [4:0] a_rx_level;
   logic [2:0] a_tx_level;
   logic [1:0] a_rx_ovf, a_tx_ovf;

   logic       b_proc_dv, b_tx_dv;
   logic [7:0] b_proc_byte, b_tx_byte;
   logic [2:0] b_rx_level;
   logic [4:0] b_tx_level;
   logic [15:0] b_rx_ovf, b_tx_ovf;

   uart_stream_router #(.TX_DEPTH(4), .PROC_GAP(3), .CNT_W(2)) dut_a (
      .i_Clk(clk), .rst(rst), .i_Mode(mode), .i_Clr_Stats(clr),
      .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
      .o_Proc_DV(a_proc_dv), .o_Proc_Byte(a_proc_byte),
      .i_Proc_DV(proc_dv_in), .i_Proc_Byte(proc_byte_in),
      .i_Tx_Active(tx_active_in), .i_Tx_Done(tx_done),
      .o_Tx_DV(a_tx_dv), .o_Tx_Byte(a_tx_byte),
      .o_Rx_Level(a_rx_level), .o_Tx_Level(a_tx_level),
      .o_Rx_Ovf_Cnt(a_rx_ovf), .o_Tx_Ovf_Cnt(a_tx_ovf)
   );

   uart_stream_router #(.RX_DEPTH(4), .PROC_GAP(100)) dut_b (
      .i_Clk(clk), .rst(rst), .i_Mode(mode), .i_Clr_Stats(clr),
      .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
      .o_Proc_DV(b_proc_dv), .o_Proc_Byte(b_proc_byte),
      .i_Proc_DV(proc_dv_in), .i_Proc_Byte(proc_byte_in),
      .i_Tx_Active(tx_active_in), .i_Tx_Done(tx_done),
      .o_Tx_DV(b_tx_dv), .o_Tx_Byte(b_tx_byte),
      .o_Rx_Level(b_rx_level), .o_Tx_Level(b_tx_level),
      .o_Rx_Ovf_Cnt(b_rx_ovf), .o_Tx_Ovf_Cnt(b_tx_ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event logs for dut_a pulses
   logic [7:0] tx_log[$];
   int         proc_log[$];
   always @(negedge clk) begin
      if (a_tx_dv)   tx_log.push_back(a_tx_byte);
      if (a_proc_dv) proc_log.push_back(cyc);
   end

   // TX core model: done strobe 20 cycles after each start
   always @(negedge clk) begin
      tx_done = 1'b0;
      if (rst) begin
         tx_busy = 1'b0;
         tx_cnt  = 0;
      end else if (a_tx_dv) begin
         tx_busy = 1'b1;
         tx_cnt  = 20;
      end else if (tx_busy) begin
         tx_cnt = tx_cnt - 1;
         if (tx_cnt == 0) begin
            tx_done = 1'b1;
            tx_busy = 1'b0;
         end
      end
   end

   // Processor echo model: returns the inverted byte in the strobe cycle
   always @(negedge clk) begin
      echo_dv   = echo_en && a_proc_dv;
      echo_byte = ~a_proc_byte;
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_rx(input logic [7:0] b);
      rx_byte = b;
      rx_dv   = 1'b1;
      tick(1);
      rx_dv   = 1'b0;
   endtask

   task automatic do_reset(input logic [1:0] m);
      mode = m;
      rst  = 1'b1;
      tick(2);
      rst  = 1'b0;
      tick(2);
   endtask

   function automatic logic [7:0] tx_at(input int idx);
      if (idx < tx_log.size()) return tx_log[idx];
      return 8'hxx;
   endfunction

   int s_tx, s_pr;
   logic [7:0] exp_b[4];

   initial begin
      // Reset state
      tick(2);
      check("rst_a_tx_dv",    {31'd0, a_tx_dv},   32'd0);
      check("rst_a_proc_dv",  {31'd0, a_proc_dv}, 32'd0);
      check("rst_a_rx_level", {27'd0, a_rx_level}, 32'd0);
      check("rst_b_tx_level", {27'd0, b_tx_level}, 32'd0);
      check("rst_a_tx_byte",  {24'd0, a_tx_byte}, 32'd0);

      // 1: loopback of three spaced bytes
      do_reset(2'd1);
      s_tx = tx_log.size();
      s_pr = proc_log.size();
      push_rx(8'h41); tick(9);
      push_rx(8'h42); tick(9);
      push_rx(8'h43); tick(100);
      check("t1_tx_count", tx_log.size() - s_tx, 32'd3);
      check("t1_tx_b0", {24'd0, tx_at(s_tx)},     32'h41);
      check("t1_tx_b1", {24'd0, tx_at(s_tx + 1)}, 32'h42);
      check("t1_tx_b2", {24'd0, tx_at(s_tx + 2)}, 32'h43);
      check("t1_proc_count", proc_log.size() - s_pr, 32'd0);

      // 2: processed path, PROC_GAP 3, echo inverts each byte
      echo_en = 1'b1;
      do_reset(2'd0);
      s_tx = tx_log.size();
      s_pr = proc_log.size();
      push_rx(8'h41);
      push_rx(8'h42);
      push_rx(8'h43);
      push_rx(8'h44);
      tick(150);
      check("t2_proc_count", proc_log.size() - s_pr, 32'd4);
      for (int i = 1; i < 4; i++) begin
         if (s_pr + i < proc_log.size())
            check($sformatf("t2_proc_gap%0d", i),
                  proc_log[s_pr + i] - proc_log[s_pr + i - 1], 32'd4);
         else
            check($sformatf("t2_proc_gap%0d", i), 32'hFFFF_FFFF, 32'd4);
      end
      exp_b[0] = 8'hBE; exp_b[1] = 8'hBD; exp_b[2] = 8'hBC; exp_b[3] = 8'hBB;
      check("t2_tx_count", tx_log.size() - s_tx, 32'd4);
      for (int i = 0; i < 4; i++)
         check($sformatf("t2_tx_b%0d", i), {24'd0, tx_at(s_tx + i)}, {24'd0, exp_b[i]});
      echo_en = 1'b0;

      // 3: dut_b RX overflow with stalled processor, clear beats increment
      do_reset(2'd0);
      push_rx(8'h10);
      tick(3);
      check("t3_b_level_pre", {29'd0, b_rx_level}, 32'd0);
      for (int i = 0; i < 6; i++) push_rx(8'h11 + 8'(i));
      check("t3_b_rx_level", {29'd0, b_rx_level}, 32'd4);
      check("t3_b_rx_ovf",   {16'd0, b_rx_ovf},   32'd2);
      clr = 1'b1;
      push_rx(8'h17);
      clr = 1'b0;
      check("t3_b_ovf_clr",  {16'd0, b_rx_ovf},   32'd0);
      check("t3_b_level_hold", {29'd0, b_rx_level}, 32'd4);

      // 4: dut_a TX overflow saturates at 3 (CNT_W = 2)
      hold_active = 1'b1;
      do_reset(2'd0);
      tb_proc_byte = 8'h5A;
      tb_proc_dv = 1'b1;
      tick(4);
      tb_proc_dv = 1'b0;
      check("t4_tx_level", {29'd0, a_tx_level}, 32'd4);
      check("t4_ovf_zero", {30'd0, a_tx_ovf},   32'd0);
      tb_proc_dv = 1'b1;
      tick(3);
      tb_proc_dv = 1'b0;
      check("t4_ovf_three", {30'd0, a_tx_ovf}, 32'd3);
      tb_proc_dv = 1'b1;
      tick(2);
      tb_proc_dv = 1'b0;
      check("t4_ovf_sat", {30'd0, a_tx_ovf}, 32'd3);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("t4_ovf_clr", {30'd0, a_tx_ovf}, 32'd0);
      hold_active = 1'b0;

      // 5: discard mode
      do_reset(2'd2);
      s_tx = tx_log.size();
      s_pr = proc_log.size();
      push_rx(8'h71);
      push_rx(8'h72);
      push_rx(8'h73);
      tick(3);
      check("t5_rx_level", {27'd0, a_rx_level}, 32'd0);
      tick(10);
      check("t5_proc_count", proc_log.size() - s_pr, 32'd0);
      check("t5_tx_count",   tx_log.size() - s_tx,   32'd0);
      check("t5_rx_ovf",     {30'd0, a_rx_ovf},      32'd0);

      // 6: asynchronous reset during WAIT with two bytes queued
      do_reset(2'd1);
      push_rx(8'h61);
      push_rx(8'h62);
      push_rx(8'h63);
      tick(8);
      check("t6_pre_tx_level", {29'd0, a_tx_level}, 32'd2);
      check("t6_pre_tx_byte",  {24'd0, a_tx_byte},  32'h61);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("t6_tx_dv",     {31'd0, a_tx_dv},    32'd0);
      check("t6_tx_byte",   {24'd0, a_tx_byte},  32'd0);
      check("t6_rx_level",  {27'd0, a_rx_level}, 32'd0);
      check("t6_tx_level",  {29'd0, a_tx_level}, 32'd0);
      check("t6_proc_dv",   {31'd0, a_proc_dv},  32'd0);
      tick(2);
      rst = 1'b0;
      s_tx = tx_log.size();
      tick(40);
      check("t6_no_tx_after", tx_log.size() - s_tx, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
